// File: rtl/register_writeback.sv
// Writeback stage plus 16x32 architectural register file: one-entry valid/ready
// buffer from memory access, commit on load-data arrival, same-cycle read bypass.
module register_writeback #(
    parameter int unsigned NREGS    = 16,
    parameter int unsigned RA_INDEX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ma_valid,
    output logic        ma_ready,
    input  logic [4:0]  ma_opcode,
    input  logic [3:0]  ma_rd,
    input  logic [31:0] ma_alu_result,
    input  logic [31:0] ma_pc,
    input  logic [31:0] ld_data,
    input  logic        ld_data_valid,
    input  logic [3:0]  a1,
    input  logic [3:0]  a2,
    output logic [31:0] d1,
    output logic [31:0] d2,
    output logic        busy,
    output logic [3:0]  busy_rd,
    output logic [31:0] retired
);

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_CALL = 5'd19;

    logic [DW-1:0] rf_q [NREGS];

    logic          valid_q, valid_d;
    logic          we_q, we_d;
    logic          isld_q, isld_d;
    logic [AW-1:0] dest_q, dest_d;
    logic [DW-1:0] value_q, value_d;
    logic [DW-1:0] retired_q, retired_d;

    logic          commit_c;
    logic          accept_c;
    logic          wr_en_c;
    logic [DW-1:0] commit_val_c;

    // Opcode decode: which incoming instructions write a register.
    always_comb begin
        wr_en_c = 1'b0;
        case (ma_opcode)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4,
            5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
            OP_LD, OP_CALL: wr_en_c = 1'b1;
            default:        wr_en_c = 1'b0;
        endcase
    end

    assign commit_c     = valid_q && (!isld_q || ld_data_valid);
    assign ma_ready     = !valid_q || commit_c;
    assign accept_c     = ma_valid && ma_ready;
    assign commit_val_c = isld_q ? ld_data : value_q;

    // Buffer next state: a new accept replaces a committing entry.
    always_comb begin
        valid_d   = valid_q;
        we_d      = we_q;
        isld_d    = isld_q;
        dest_d    = dest_q;
        value_d   = value_q;
        retired_d = retired_q;
        if (commit_c) begin
            valid_d   = 1'b0;
            retired_d = retired_q + DW'(1);
        end
        if (accept_c) begin
            valid_d = 1'b1;
            we_d    = wr_en_c;
            isld_d  = (ma_opcode == OP_LD);
            dest_d  = (ma_opcode == OP_CALL) ? AW'(RA_INDEX) : ma_rd;
            value_d = (ma_opcode == OP_CALL) ? ma_pc + DW'(4) : ma_alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf_q[i] <= '0;
            end
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            isld_q    <= 1'b0;
            dest_q    <= '0;
            value_q   <= '0;
            retired_q <= '0;
        end else begin
            if (commit_c && we_q) begin
                rf_q[dest_q] <= commit_val_c;
            end
            valid_q   <= valid_d;
            we_q      <= we_d;
            isld_q    <= isld_d;
            dest_q    <= dest_d;
            value_q   <= value_d;
            retired_q <= retired_d;
        end
    end

    // Bypass the committing value so operand fetch sees it in the commit cycle.
    assign d1 = (commit_c && we_q && dest_q == a1) ? commit_val_c : rf_q[a1];
    assign d2 = (commit_c && we_q && dest_q == a2) ? commit_val_c : rf_q[a2];

    assign busy    = valid_q && we_q;
    assign busy_rd = busy ? dest_q : '0;
    assign retired = retired_q;

endmodule

// File: doc/register_writeback.md
# register_writeback

Writeback stage and architectural register file of the 32-bit RISC pipeline, the write-side counterpart of operand fetch. It holds sixteen 32-bit registers and serves operand fetch's two combinational read ports (a1→d1, a2→d2) with same-cycle write bypass. It latches completed instructions from the memory-access stage through a one-entry valid/ready buffer. It resolves the writeback value (ALU result, load data, or return address) and commits it to rd or to r15.

## Interface
- NREGS, 16, number of architectural registers (address width 4)
- RA_INDEX, 15, register written by call
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- ma_valid  in  1  memory-access stage presents an instruction
- ma_ready  out  1  buffer can accept this cycle
- ma_opcode  in  5  opcode field [31:27]
- ma_rd  in  4  destination field [25:22]
- ma_alu_result  in  32  ALU output
- ma_pc  in  32  PC of the instruction
- ld_data  in  32  load data from data memory
- ld_data_valid  in  1  ld_data is valid this cycle
- a1, a2  in  4  operand-fetch read addresses
- d1, d2  out  32  read data (combinational)
- busy  out  1  buffer holds an uncommitted writing instruction
- busy_rd  out  4  its destination register (0 when busy=0)
- retired  out  32  count of committed instructions

## Operation
- Opcodes: add 0, sub 1, mul 2, div 3, mod 4, cmp 5, and 6, or 7, not 8, mov 9, lsl 10, lsr 11, asr 12, nop 13, ld 14, st 15, beq 16, bgt 17, b 18, call 19, ret 20. Codes 21–31 are treated as nop.
- Write enable: opcodes 0–4, 6–12, 14, 19. All others retire without writing.
- Destination: RA_INDEX for call, otherwise ma_rd.
- Value:
  - ld → ld_data at commit time.
  - call → ma_pc + 4, mod 2^32.
  - otherwise → ma_alu_result.
- Buffer fields: valid, we, isld, dest[3:0], value[31:0], latched on accept (ma_valid && ma_ready). For a load, value is left undefined until commit.
- commit = valid && (!isld || ld_data_valid).
  - On commit with we=1, the register at dest takes the value (ld_data if isld).
  - retired increments by 1, wrapping at 2^32.
- ma_ready = !valid || commit. Accept and commit may occur in the same cycle; the new entry replaces the committing one.
- If valid && !commit, nothing changes. ma_ready stays 0 until the load data arrives.
- Reads:
  - d1 = ld_data if commit && we && dest==a1 && isld; value if commit && we && dest==a1 && !isld; otherwise rf[a1]. d2 is the same with a2.
  - r0 is an ordinary writable register; it has no hardwired zero.
- busy = valid && we; busy_rd = dest when busy, else 0. The hazard unit stalls on busy_rd match while !commit; read data is stale in that window.

## Timing
- Reset (synchronous, while reset=1 at the edge): all 16 registers = 0, valid = 0, retired = 0. Outputs after reset: ma_ready = 1, busy = 0, busy_rd = 0, d1 = d2 = 0.
- Reset overrides everything: a pending load is discarded, no write occurs, and retired is not incremented in that cycle.
- Latency: accepted at edge N; register written at edge N+1 if commit holds in cycle N+1. Otherwise written at the first later edge with ld_data_valid=1.
- The bypass makes the committing value visible on d1/d2 in the commit cycle; rf shows it from the next cycle.
- Throughput: one instruction per cycle for non-load instructions and for loads whose ld_data_valid is 1 in the cycle after accept.
- ma_ready is combinational from valid, isld and ld_data_valid. ma_valid may be asserted and then held without ma_ready; there is no requirement on the producer to keep inputs stable.
- ld_data_valid while valid=0 or isld=0 is ignored.

## Test plan
- Reset then read: a1=3, a2=15 → d1=d2=0, ma_ready=1, retired=0.
- add to rd=5 with alu_result=0x1234_5678: accept at edge N. In cycle N+1, a1=5 → d1=0x1234_5678 via bypass. From N+2, rf[5]=0x1234_5678, retired=1.
- ld to rd=7 with ld_data_valid low for 3 cycles: ma_ready=0, busy=1, busy_rd=7 throughout. Then ld_data=0xDEAD_BEEF with ld_data_valid=1 → same-cycle d2=0xDEAD_BEEF for a2=7, ma_ready=1, rf[7] written.
- call with ma_pc=0xFFFF_FFFC, ma_rd=3 → r15=0x0000_0000 and r3 unchanged. cmp, st, beq, b and nop each increment retired with no register change.
- Back-to-back add r1 (value 10) then sub r1 (value 20) every cycle → d1 for a1=1 shows 10 then 20. Final rf[1]=20, retired=2.
- Pending load to r9, then reset asserted for one cycle → rf[9]=0, retired=0, ma_ready=1, busy=0. A later ld_data_valid with no pending load has no effect.
